// File: rtl/cunit_seq_if.sv
// Handshake/strobe bundle for the noise-cancellation frame sequencer.
// master drives the controls, slave is the sequencer itself.
interface cunit_seq_if #(
  parameter int CH = 2
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

  logic             start;
  logic             continuous;
  logic             abort;
  logic             in_valid;
  logic [CH-1:0]    wrreq_in;
  logic [CH-1:0]    rdreq_in;
  logic [SEL_W-1:0] sel_ch;
  logic             fft_enable;
  logic             fft_inverse;
  logic             wrreq_spec;
  logic             nios_req;
  logic             nios_done;
  logic             rdreq_ret;
  logic             wrreq_out;
  logic             out_req;
  logic             out_ack;
  logic             busy;
  logic             err;
  logic [15:0]      frame_cnt;
  logic [3:0]       state;

  modport master (
    output start, continuous, abort, in_valid,
    output nios_done, out_ack,
    input  wrreq_in, rdreq_in, sel_ch,
    input  fft_enable, fft_inverse, wrreq_spec,
    input  nios_req, rdreq_ret, wrreq_out,
    input  out_req, busy, err, frame_cnt, state
  );

  modport slave (
    input  start, continuous, abort, in_valid,
    input  nios_done, out_ack,
    output wrreq_in, rdreq_in, sel_ch,
    output fft_enable, fft_inverse, wrreq_spec,
    output nios_req, rdreq_ret, wrreq_out,
    output out_req, busy, err, frame_cnt, state
  );
endinterface

// File: rtl/cunit_seq.sv
// Counter-driven frame sequencer: fill, forward FFT, NIOS, inverse FFT,
// output handoff, with continuous mode, abort and watchdog error state.
module cunit_seq #(
  parameter int CH        = 2,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 12,
  parameter int FFT_LAT   = 4,
  parameter int TIMEOUT   = 1023
) (
  input logic        clock,
  input logic        reset,
  cunit_seq_if.slave bus
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_S  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_F  = CNT_W'(CH * FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_L  = CNT_W'(FFT_LAT - 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL      = 4'd1,
    S_FWD       = 4'd2,
    S_FWD_FLUSH = 4'd3,
    S_NIOS_WAIT = 4'd4,
    S_INV       = 4'd5,
    S_INV_FLUSH = 4'd6,
    S_OUT_WAIT  = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   ch;
  logic [WD_W-1:0]    wd;
  logic [FFT_LAT-1:0] fwd_dl;
  logic [FFT_LAT-1:0] inv_dl;
  logic [15:0]        frame_cnt_r;
  logic               err_r;

  logic [CH-1:0]    wrreq_in;
  logic [CH-1:0]    rdreq_in;
  logic [SEL_W-1:0] sel_ch;
  logic             fft_enable;
  logic             fft_inverse;
  logic             nios_req;
  logic             rdreq_ret;
  logic             out_req;

  always_comb begin
    wrreq_in    = '0;
    rdreq_in    = '0;
    sel_ch      = '0;
    fft_enable  = 1'b0;
    fft_inverse = 1'b0;
    nios_req    = 1'b0;
    rdreq_ret   = 1'b0;
    out_req     = 1'b0;
    unique case (state)
      S_FILL: wrreq_in = {CH{bus.in_valid}};
      S_FWD: begin
        rdreq_in   = CH'(1) << ch;
        sel_ch     = ch;
        fft_enable = 1'b1;
      end
      S_FWD_FLUSH: fft_enable = 1'b1;
      S_NIOS_WAIT: nios_req = 1'b1;
      S_INV: begin
        fft_enable  = 1'b1;
        fft_inverse = 1'b1;
        rdreq_ret   = 1'b1;
      end
      S_INV_FLUSH: begin
        fft_enable  = 1'b1;
        fft_inverse = 1'b1;
      end
      S_OUT_WAIT: out_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ch          <= '0;
      wd          <= '0;
      fwd_dl      <= '0;
      inv_dl      <= '0;
      frame_cnt_r <= '0;
      err_r       <= 1'b0;
    end else if (bus.abort && state != S_ERR) begin
      // flushing both delay lines keeps stale write strobes from leaking out
      state  <= S_IDLE;
      cnt    <= '0;
      ch     <= '0;
      wd     <= '0;
      fwd_dl <= '0;
      inv_dl <= '0;
    end else begin
      fwd_dl <= (fwd_dl << 1) | FFT_LAT'(|rdreq_in);
      inv_dl <= (inv_dl << 1) | FFT_LAT'(rdreq_ret);
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_FILL;
            cnt   <= '0;
            ch    <= '0;
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            if (cnt == LAST_S) begin
              state <= S_FWD;
              cnt   <= '0;
              ch    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FWD: begin
          if (cnt == LAST_S) begin
            cnt <= '0;
            if (ch == LAST_CH) state <= S_FWD_FLUSH;
            else               ch    <= ch + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FWD_FLUSH: begin
          if (cnt == LAST_L) begin
            state <= S_NIOS_WAIT;
            cnt   <= '0;
            ch    <= '0;
            wd    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NIOS_WAIT: begin
          // a late nios_done still beats the watchdog
          if (bus.nios_done) begin
            state <= S_INV;
            wd    <= '0;
          end else if (wd == WD_LAST) begin
            state <= S_ERR;
            wd    <= '0;
            err_r <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_INV: begin
          if (cnt == LAST_F) begin
            state <= S_INV_FLUSH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INV_FLUSH: begin
          if (cnt == LAST_L) begin
            state <= S_OUT_WAIT;
            cnt   <= '0;
            wd    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OUT_WAIT: begin
          if (bus.out_ack) begin
            state <= S_DONE;
            wd    <= '0;
          end else if (wd == WD_LAST) begin
            state <= S_ERR;
            wd    <= '0;
            err_r <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DONE: begin
          frame_cnt_r <= frame_cnt_r + 1'b1;
          cnt         <= '0;
          ch          <= '0;
          state       <= bus.continuous ? S_FILL : S_IDLE;
        end
        S_ERR: begin
          if (bus.start) begin
            state <= S_IDLE;
            err_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wrreq_in    = wrreq_in;
  assign bus.rdreq_in    = rdreq_in;
  assign bus.sel_ch      = sel_ch;
  assign bus.fft_enable  = fft_enable;
  assign bus.fft_inverse = fft_inverse;
  assign bus.wrreq_spec  = fwd_dl[FFT_LAT-1];
  assign bus.nios_req    = nios_req;
  assign bus.rdreq_ret   = rdreq_ret;
  assign bus.wrreq_out   = inv_dl[FFT_LAT-1];
  assign bus.out_req     = out_req;
  assign bus.busy        = (state != S_IDLE) && (state != S_ERR);
  assign bus.err         = err_r;
  assign bus.frame_cnt   = frame_cnt_r;
  assign bus.state       = state;
endmodule

// File: tb/tb_cunit_seq.sv
// Directed bench for cunit_seq: table-driven nominal frame plus
// sequences for abort, async reset, watchdog, continuous mode and wrap.
module tb_cunit_seq;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  cunit_seq_if #(.CH(2)) b ();

  cunit_seq #(
    .CH(2), .FRAME_LEN(8), .CNT_W(12), .FFT_LAT(3), .TIMEOUT(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(b)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n;
    logic        st;
    logic        iv;
    logic        nd;
    logic        ack;
    logic [33:0] exp;
  } vec_t;

  vec_t tbl[$];

  // s, wrreq_in, rdreq_in, sel, en, inv, spec, nreq, ret, wout, oreq, busy, err, fcnt
  function automatic logic [33:0] o(
    input logic [3:0] s, input logic [1:0] wi, input logic [1:0] ri,
    input logic sel, input logic en, input logic inv, input logic sp,
    input logic nr, input logic rt, input logic wo, input logic orq,
    input logic bz, input logic er, input logic [15:0] fc);
    return {s, wi, ri, sel, en, inv, sp, nr, rt, wo, orq, bz, er, fc};
  endfunction

  function automatic logic [33:0] obs();
    return {b.state, b.wrreq_in, b.rdreq_in, b.sel_ch, b.fft_enable,
            b.fft_inverse, b.wrreq_spec, b.nios_req, b.rdreq_ret,
            b.wrreq_out, b.out_req, b.busy, b.err, b.frame_cnt};
  endfunction

  function automatic void add(input int n, input logic st, input logic iv,
                              input logic nd, input logic ack,
                              input logic [33:0] e);
    tbl.push_back('{n, st, iv, nd, ack, e});
  endfunction

  task automatic chk(input string nm, input logic [33:0] got,
                     input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        b.start     = tbl[i].st;
        b.in_valid  = tbl[i].iv;
        b.nios_done = tbl[i].nd;
        b.out_ack   = tbl[i].ack;
        #1;
        chk($sformatf("%s rec%0d cyc%0d", tag, i, k), obs(), tbl[i].exp);
        cyc();
      end
    end
    b.start = 0; b.in_valid = 0; b.nios_done = 0; b.out_ack = 0;
  endtask

  task automatic fill();
    b.start = 1;
    cyc();
    b.start = 0;
    b.in_valid = 1;
    repeat (8) cyc();
    b.in_valid = 0;
  endtask

  task automatic wait_st(input logic [3:0] s, input int budget,
                         input string nm);
    int k = 0;
    while (b.state !== s && k < budget) begin
      cyc();
      k++;
    end
    chk(nm, 34'(b.state), 34'(s));
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 0;
    #2;
    reset = 1;
    cyc();
  endtask

  initial begin
    b.start = 0; b.continuous = 0; b.abort = 0;
    b.in_valid = 0; b.nios_done = 0; b.out_ack = 0;

    add(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 1, 0, 0, o(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(3, 0, 1, 0, 0, o(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(2, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(4, 0, 1, 0, 0, o(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(3, 0, 0, 0, 0, o(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(5, 0, 0, 0, 0, o(2, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    add(8, 0, 0, 0, 0, o(2, 0, 2, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    add(3, 0, 0, 0, 0, o(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    add(5, 0, 0, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    add(1, 0, 0, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    add(3, 0, 0, 0, 0, o(5, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    add(13, 0, 0, 0, 0, o(5, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0));
    add(3, 0, 0, 0, 0, o(6, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    add(2, 0, 0, 0, 0, o(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add(1, 0, 0, 0, 1, o(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add(1, 0, 0, 0, 0, o(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    #3;
    chk("reset_state", obs(), '0);
    @(negedge clock);
    reset = 1;
    cyc();

    run_tbl("nominal");

    // abort mid-FWD at ch=1, cnt=4
    fill();
    repeat (12) cyc();
    chk("abort_pre", obs(),
        o(2, 0, 2, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    b.abort = 1;
    cyc();
    b.abort = 0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort_quiet%0d", k), obs(),
          o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      cyc();
    end
    b.abort = 1;
    b.start = 1;
    cyc();
    b.abort = 0;
    b.start = 0;
    chk("abort_start_idle", obs(),
        o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // asynchronous reset in the middle of INV
    fill();
    b.nios_done = 1;
    wait_st(5, 40, "reach_inv");
    b.nios_done = 0;
    repeat (2) cyc();
    @(posedge clock);
    #3;
    reset = 0;
    #1;
    chk("async_reset", obs(), '0);
    @(negedge clock);
    reset = 1;
    cyc();
    run_tbl("after_reset");

    // watchdog expiry in NIOS_WAIT
    fill();
    wait_st(4, 30, "reach_nios");
    begin
      int n = 0;
      while (b.state === 4'd4 && n < 40) begin
        cyc();
        n++;
      end
      chk("wd_cycles", 34'(n), 34'd20);
    end
    chk("err_state", obs(),
        o(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    b.abort = 1;
    cyc();
    b.abort = 0;
    chk("err_abort_held", obs(),
        o(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    b.start = 1;
    cyc();
    b.start = 0;
    chk("err_clear", obs(),
        o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // nios_done on the last watchdog cycle still wins
    fill();
    wait_st(4, 30, "reach_nios2");
    repeat (19) cyc();
    chk("wd_last_cycle", obs(),
        o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    b.nios_done = 1;
    cyc();
    b.nios_done = 0;
    chk("wd_done_wins", obs(),
        o(5, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1));
    wait_st(7, 40, "reach_out");
    b.out_ack = 1;
    cyc();
    b.out_ack = 0;
    cyc();
    chk("frame2_done", obs(),
        o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));

    // continuous mode, three frames back to back
    pulse_reset();
    b.continuous = 1;
    b.in_valid = 1;
    b.nios_done = 1;
    b.out_ack = 1;
    b.start = 1;
    cyc();
    b.start = 0;
    begin
      int dones = 0;
      int drops = 0;
      int k = 0;
      while (dones < 3 && k < 400) begin
        if (b.busy !== 1'b1) drops++;
        if (b.state === 4'd8) begin
          dones++;
          cyc();
          chk($sformatf("cont_refill%0d", dones), 34'(b.state), 34'd1);
        end else begin
          cyc();
        end
        k++;
      end
      chk("cont_dones", 34'(dones), 34'd3);
      chk("cont_busy_drops", 34'(drops), 34'd0);
      chk("cont_frame_cnt", 34'(b.frame_cnt), 34'd3);
    end
    b.abort = 1;
    cyc();
    b.abort = 0;
    b.continuous = 0;
    chk("cont_abort", obs(),
        o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));

    // frame counter wrap
    force dut.frame_cnt_r = 16'hFFFF;
    #1;
    release dut.frame_cnt_r;
    chk("wrap_preload", 34'(b.frame_cnt), 34'hFFFF);
    b.start = 1;
    cyc();
    b.start = 0;
    wait_st(8, 100, "wrap_reach_done");
    cyc();
    chk("wrap_zero", obs(),
        o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    b.in_valid = 0;
    b.nios_done = 0;
    b.out_ack = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
